// File: rtl/l1_sram_port_arbiter.sv
// l1_sram_port_arbiter: shares the L1 dual-port SRAM between refill/store writers and load/writeback readers.
// Define L1_SRAM_ARB_BYPASS_EN to forward same-cycle write data into a same-address read instead of blocking it.
module l1_sram_port_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 1024,
  parameter int NUM_WMASKS   = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fill_wr_valid,
  output logic                  fill_wr_ready,
  input  logic [ADDR_WIDTH-1:0] fill_wr_addr,
  input  logic [DATA_WIDTH-1:0] fill_wr_data,
  input  logic                  st_wr_valid,
  output logic                  st_wr_ready,
  input  logic [ADDR_WIDTH-1:0] st_wr_addr,
  input  logic [DATA_WIDTH-1:0] st_wr_data,
  input  logic [NUM_WMASKS-1:0] st_wr_mask,
  input  logic                  ld_rd_valid,
  output logic                  ld_rd_ready,
  input  logic [ADDR_WIDTH-1:0] ld_rd_addr,
  input  logic                  wb_rd_valid,
  output logic                  wb_rd_ready,
  input  logic [ADDR_WIDTH-1:0] wb_rd_addr,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);
  localparam int BW = DATA_WIDTH / NUM_WMASKS;
  logic [3:0] starve_cnt;
  logic rd_ptr, st_win, wr_en, pick_wb, rd_req, rd_go, hit;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  // Grants are gated by rst_n so every ready and chip select is idle while reset is held.
  always_comb begin
    st_win        = rst_n & st_wr_valid & (!fill_wr_valid | starve_cnt == 4'(STARVE_LIMIT));
    fill_wr_ready = rst_n & fill_wr_valid & !st_win;
    st_wr_ready   = st_win;
    wr_en         = fill_wr_ready | st_win;
    wr_addr       = st_win ? st_wr_addr : fill_wr_addr;
    pick_wb       = wb_rd_valid & (!ld_rd_valid | rd_ptr);
    rd_req        = rst_n & (ld_rd_valid | wb_rd_valid);
    rd_addr       = pick_wb ? wb_rd_addr : ld_rd_addr;
    hit           = wr_en & rd_req & rd_addr == wr_addr;
`ifdef L1_SRAM_ARB_BYPASS_EN
    rd_go         = rd_req;
`else
    rd_go         = rd_req & !hit;
`endif
    ld_rd_ready   = rd_go & !pick_wb;
    wb_rd_ready   = rd_go & pick_wb;
    sram_csb0     = !wr_en;
    sram_addr0    = wr_en ? wr_addr : '0;
    sram_wmask0   = fill_wr_ready ? '1 : st_win ? st_wr_mask : '0;
    sram_din0     = fill_wr_ready ? fill_wr_data : st_win ? st_wr_data : '0;
    sram_csb1     = !rd_go;
    sram_addr1    = rd_go ? rd_addr : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      rd_ptr     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      if (st_wr_ready) starve_cnt <= '0;
      else if (st_wr_valid && starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
      if (rd_go) rd_ptr <= !pick_wb;
      rsp_valid <= rd_go;
      rsp_id    <= rd_go & pick_wb;
    end
  end
`ifdef L1_SRAM_ARB_BYPASS_EN
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_data;
  logic [NUM_WMASKS-1:0] byp_mask;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
      byp_mask <= '0;
    end else begin
      byp_hit <= hit;
      if (hit) begin
        byp_data <= sram_din0;
        byp_mask <= sram_wmask0;
      end
    end
  end
  // The macro returns pre-write contents on a same-address collision; overlay the written bytes.
  always_comb begin
    rsp_data = '0;
    if (rsp_valid)
      for (int i = 0; i < NUM_WMASKS; i++)
        rsp_data[i*BW +: BW] = (byp_hit & byp_mask[i]) ? byp_data[i*BW +: BW] : sram_dout1[i*BW +: BW];
  end
`else
  always_comb rsp_data = rsp_valid ? sram_dout1 : '0;
`endif
endmodule

// File: tb/tb_l1_sram_port_arbiter.sv
// tb_l1_sram_port_arbiter: directed and randomized checks of l1_sram_port_arbiter against a behavioural model.
module tb_l1_sram_port_arbiter;
  localparam int AW = 8, DW = 1024, NM = 128, SL = 4;
`ifdef L1_SRAM_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic fill_wr_valid, fill_wr_ready, st_wr_valid, st_wr_ready;
  logic ld_rd_valid, ld_rd_ready, wb_rd_valid, wb_rd_ready;
  logic [AW-1:0] fill_wr_addr, st_wr_addr, ld_rd_addr, wb_rd_addr, sram_addr0, sram_addr1;
  logic [DW-1:0] fill_wr_data, st_wr_data, rsp_data, sram_din0, dout;
  logic [NM-1:0] st_wr_mask, sram_wmask0;
  logic rsp_valid, rsp_id, sram_csb0, sram_csb1;
  int checks = 0, errors = 0;
  logic [DW-1:0] smem [256];
  logic [DW-1:0] ref_mem [256];
  logic seed_v = 1'b0;
  logic [AW-1:0] seed_a;
  logic [DW-1:0] seed_d;

  l1_sram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .fill_wr_valid(fill_wr_valid), .fill_wr_ready(fill_wr_ready),
    .fill_wr_addr(fill_wr_addr), .fill_wr_data(fill_wr_data),
    .st_wr_valid(st_wr_valid), .st_wr_ready(st_wr_ready), .st_wr_addr(st_wr_addr),
    .st_wr_data(st_wr_data), .st_wr_mask(st_wr_mask),
    .ld_rd_valid(ld_rd_valid), .ld_rd_ready(ld_rd_ready), .ld_rd_addr(ld_rd_addr),
    .wb_rd_valid(wb_rd_valid), .wb_rd_ready(wb_rd_ready), .wb_rd_addr(wb_rd_addr),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(dout)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [NM-1:0] m);
    merge = o;
    for (int i = 0; i < NM; i++) if (m[i]) merge[i*8 +: 8] = n[i*8 +: 8];
  endfunction

  function automatic logic [DW-1:0] rnd_line();
    for (int i = 0; i < DW/32; i++) rnd_line[i*32 +: 32] = $urandom();
  endfunction

  // SRAM macro model: synchronous masked write, synchronous read returning pre-write contents.
  always @(posedge clk) begin
    if (seed_v) smem[seed_a] <= seed_d;
    else if (!sram_csb0) smem[sram_addr0] <= merge(smem[sram_addr0], sram_din0, sram_wmask0);
    if (!sram_csb1) dout <= smem[sram_addr1];
  end

  task automatic test_reset();
    rst_n = 1'b0;
    fill_wr_valid = 1'b1; fill_wr_addr = 8'h01; fill_wr_data = rnd_line();
    st_wr_valid = 1'b1; st_wr_addr = 8'h02; st_wr_data = rnd_line(); st_wr_mask = '1;
    ld_rd_valid = 1'b1; ld_rd_addr = 8'h03; wb_rd_valid = 1'b1; wb_rd_addr = 8'h04;
    #1;
    checks++; if ({sram_csb0, sram_csb1} !== 2'b11) begin errors++; $display("FAIL reset_csb got %b want 11", {sram_csb0, sram_csb1}); end
    checks++; if ({fill_wr_ready, st_wr_ready, ld_rd_ready, wb_rd_ready} !== 4'b0000) begin errors++; $display("FAIL reset_readys got %b want 0000", {fill_wr_ready, st_wr_ready, ld_rd_ready, wb_rd_ready}); end
    checks++; if ({rsp_valid, rsp_id} !== 2'b00) begin errors++; $display("FAIL reset_rsp got %b want 00", {rsp_valid, rsp_id}); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data[127:0]); end
    checks++; if ({sram_addr0, sram_addr1, sram_wmask0} !== '0) begin errors++; $display("FAIL reset_sram_ctl got %h %h %h want 0", sram_addr0, sram_addr1, sram_wmask0); end
    checks++; if (sram_din0 !== '0) begin errors++; $display("FAIL reset_din0 got %h want 0", sram_din0[127:0]); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if ({fill_wr_ready, st_wr_ready, ld_rd_ready, wb_rd_ready} !== 4'b1010) begin errors++; $display("FAIL release_readys got %b want 1010", {fill_wr_ready, st_wr_ready, ld_rd_ready, wb_rd_ready}); end
    checks++; if ({sram_csb0, sram_csb1} !== 2'b00) begin errors++; $display("FAIL release_csb got %b want 00", {sram_csb0, sram_csb1}); end
    #1 rst_n = 1'b0;
    fill_wr_valid = 1'b0; st_wr_valid = 1'b0; ld_rd_valid = 1'b0; wb_rd_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_starvation();
    logic e_st;
    fill_wr_valid = 1'b1; fill_wr_addr = 8'h40; fill_wr_data = rnd_line();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i % 5 == 0) begin
        st_wr_valid = 1'b1; st_wr_addr = 8'h41; st_wr_data = rnd_line();
        st_wr_mask = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      #1;
      e_st = (i % 5 == 4);
      checks++; if ({fill_wr_ready, st_wr_ready} !== {!e_st, e_st}) begin errors++; $display("FAIL starve_grant cyc %0d got %b want %b", i, {fill_wr_ready, st_wr_ready}, {!e_st, e_st}); end
      checks++; if (sram_wmask0 !== (e_st ? st_wr_mask : {NM{1'b1}})) begin errors++; $display("FAIL starve_wmask cyc %0d got %h want %h", i, sram_wmask0, e_st ? st_wr_mask : {NM{1'b1}}); end
      checks++; if (sram_addr0 !== (e_st ? 8'h41 : 8'h40)) begin errors++; $display("FAIL starve_addr0 cyc %0d got %h", i, sram_addr0); end
      if (e_st) ref_mem[8'h41] = merge(ref_mem[8'h41], st_wr_data, st_wr_mask);
      else ref_mem[8'h40] = fill_wr_data;
    end
    @(negedge clk); fill_wr_valid = 1'b0; st_wr_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    logic pv, pid, e_wb;
    logic [DW-1:0] pd;
    pv = 1'b0; pid = 1'b0; pd = '0;
    ld_rd_addr = 8'h10; wb_rd_addr = 8'h20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ld_rd_valid = i < 4; wb_rd_valid = i < 4;
      #1;
      e_wb = (i % 2 == 1);
      if (i < 4) begin
        checks++; if ({ld_rd_ready, wb_rd_ready} !== {!e_wb, e_wb}) begin errors++; $display("FAIL rr_grant cyc %0d got %b want %b", i, {ld_rd_ready, wb_rd_ready}, {!e_wb, e_wb}); end
        checks++; if (sram_addr1 !== (e_wb ? 8'h20 : 8'h10)) begin errors++; $display("FAIL rr_addr1 cyc %0d got %h", i, sram_addr1); end
      end
      checks++; if (rsp_valid !== pv) begin errors++; $display("FAIL rr_rsp_valid cyc %0d got %b want %b", i, rsp_valid, pv); end
      if (pv) begin
        checks++; if (rsp_id !== pid) begin errors++; $display("FAIL rr_rsp_id cyc %0d got %b want %b", i, rsp_id, pid); end
        checks++; if (rsp_data !== pd) begin errors++; $display("FAIL rr_rsp_data cyc %0d got %h want %h", i, rsp_data[127:0], pd[127:0]); end
      end
      pv = i < 4; pid = e_wb; pd = ref_mem[e_wb ? 8'h20 : 8'h10];
    end
  endtask

  task automatic test_conflict();
    logic [DW-1:0] old, d;
    @(negedge clk);
    old = ref_mem[8'h33]; d = rnd_line(); d[7:0] = 8'hAB;
    st_wr_valid = 1'b1; st_wr_addr = 8'h33; st_wr_data = d; st_wr_mask = 128'h1;
    ld_rd_valid = 1'b1; ld_rd_addr = 8'h33;
    #1;
    checks++; if (st_wr_ready !== 1'b1) begin errors++; $display("FAIL conflict_st_ready got %b want 1", st_wr_ready); end
    checks++; if ({ld_rd_ready, sram_csb1} !== {BYP, !BYP}) begin errors++; $display("FAIL conflict_ld_block got %b want %b", {ld_rd_ready, sram_csb1}, {BYP, !BYP}); end
    ref_mem[8'h33] = merge(old, d, 128'h1);
    @(negedge clk); st_wr_valid = 1'b0;
`ifndef L1_SRAM_ARB_BYPASS_EN
    #1;
    checks++; if ({ld_rd_ready, sram_addr1} !== {1'b1, 8'h33}) begin errors++; $display("FAIL conflict_retry got %b/%h want 1/33", ld_rd_ready, sram_addr1); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL conflict_no_rsp got %b want 0", rsp_valid); end
    @(negedge clk);
`endif
    ld_rd_valid = 1'b0; #1;
    checks++; if ({rsp_valid, rsp_id} !== 2'b10) begin errors++; $display("FAIL conflict_rsp got %b want 10", {rsp_valid, rsp_id}); end
    checks++; if (rsp_data[7:0] !== 8'hAB) begin errors++; $display("FAIL conflict_byte0 got %h want ab", rsp_data[7:0]); end
    checks++; if (rsp_data !== ref_mem[8'h33]) begin errors++; $display("FAIL conflict_line got %h want %h", rsp_data[127:0], ref_mem[8'h33][127:0]); end
`ifdef L1_SRAM_ARB_BYPASS_EN
    checks++; if (rsp_data[DW-1:8] !== old[DW-1:8]) begin errors++; $display("FAIL bypass_other_bytes got %h want %h", rsp_data[127:8], old[127:8]); end
`endif
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    ld_rd_valid = 1'b1; ld_rd_addr = 8'h05; #1;
    checks++; if (ld_rd_ready !== 1'b1) begin errors++; $display("FAIL midrst_grant got %b want 1", ld_rd_ready); end
    @(posedge clk); #1 rst_n = 1'b0; ld_rd_valid = 1'b0; #1;
    checks++; if ({rsp_valid, sram_csb0, sram_csb1} !== 3'b011) begin errors++; $display("FAIL midrst_outputs got %b want 011", {rsp_valid, sram_csb0, sram_csb1}); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL midrst_rsp_data got %h want 0", rsp_data[127:0]); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_release got %b want 0", rsp_valid); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_after got %b want 0", rsp_valid); end
  endtask

  task automatic test_random();
    logic pv, pid, last_wb, gf, gs, gl, gw, e_st, e_f, wr, rd, pick, go;
    logic [AW-1:0] wa, ra;
    logic [NM-1:0] wm;
    logic [DW-1:0] wd, pd;
    int starve;
    pv = 1'b0; pid = 1'b0; pd = '0; starve = 0; last_wb = 1'b1;
    gf = 1'b0; gs = 1'b0; gl = 1'b0; gw = 1'b0;
    for (int c = 0; c <= 400; c++) begin
      @(negedge clk);
      if (gf) fill_wr_valid = 1'b0;
      if (gs) st_wr_valid = 1'b0;
      if (gl) ld_rd_valid = 1'b0;
      if (gw) wb_rd_valid = 1'b0;
      if (c == 400) begin
        fill_wr_valid = 1'b0; st_wr_valid = 1'b0; ld_rd_valid = 1'b0; wb_rd_valid = 1'b0;
      end else begin
        if (!fill_wr_valid && $urandom_range(9, 0) < 6) begin
          fill_wr_valid = 1'b1; fill_wr_addr = 8'($urandom_range(3, 0)); fill_wr_data = rnd_line();
        end
        if (!st_wr_valid && $urandom_range(9, 0) < 6) begin
          st_wr_valid = 1'b1; st_wr_addr = 8'($urandom_range(3, 0)); st_wr_data = rnd_line();
          st_wr_mask = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        if (!ld_rd_valid && $urandom_range(9, 0) < 6) begin ld_rd_valid = 1'b1; ld_rd_addr = 8'($urandom_range(3, 0)); end
        if (!wb_rd_valid && $urandom_range(9, 0) < 6) begin wb_rd_valid = 1'b1; wb_rd_addr = 8'($urandom_range(3, 0)); end
      end
      #1;
      e_st = st_wr_valid && (!fill_wr_valid || starve == SL);
      e_f  = fill_wr_valid && !e_st;
      wr   = e_st || e_f;
      wa   = e_st ? st_wr_addr : fill_wr_addr;
      wm   = e_st ? st_wr_mask : {NM{1'b1}};
      wd   = e_st ? st_wr_data : fill_wr_data;
      rd   = ld_rd_valid || wb_rd_valid;
      pick = (ld_rd_valid && wb_rd_valid) ? !last_wb : wb_rd_valid;
      ra   = pick ? wb_rd_addr : ld_rd_addr;
      go   = rd && (BYP || !(wr && ra == wa));
      checks++; if ({fill_wr_ready, st_wr_ready, ld_rd_ready, wb_rd_ready} !== {e_f, e_st, go && !pick, go && pick}) begin errors++; $display("FAIL rnd_readys cyc %0d got %b want %b", c, {fill_wr_ready, st_wr_ready, ld_rd_ready, wb_rd_ready}, {e_f, e_st, go && !pick, go && pick}); end
      checks++; if ({sram_csb0, sram_csb1} !== {!wr, !go}) begin errors++; $display("FAIL rnd_csb cyc %0d got %b want %b", c, {sram_csb0, sram_csb1}, {!wr, !go}); end
      if (wr) begin
        checks++; if ({sram_addr0, sram_wmask0} !== {wa, wm}) begin errors++; $display("FAIL rnd_wr_ctl cyc %0d got %h/%h want %h/%h", c, sram_addr0, sram_wmask0, wa, wm); end
        checks++; if (sram_din0 !== wd) begin errors++; $display("FAIL rnd_din0 cyc %0d got %h want %h", c, sram_din0[127:0], wd[127:0]); end
      end
      if (go) begin
        checks++; if (sram_addr1 !== ra) begin errors++; $display("FAIL rnd_addr1 cyc %0d got %h want %h", c, sram_addr1, ra); end
      end
      checks++; if (rsp_valid !== pv) begin errors++; $display("FAIL rnd_rsp_valid cyc %0d got %b want %b", c, rsp_valid, pv); end
      if (pv) begin
        checks++; if (rsp_id !== pid) begin errors++; $display("FAIL rnd_rsp_id cyc %0d got %b want %b", c, rsp_id, pid); end
        checks++; if (rsp_data !== pd) begin errors++; $display("FAIL rnd_rsp_data cyc %0d got %h want %h", c, rsp_data[127:0], pd[127:0]); end
      end
      if (wr) ref_mem[wa] = merge(ref_mem[wa], wd, wm);
      pv = go; pid = pick; pd = ref_mem[ra];
      if (e_st) starve = 0;
      else if (st_wr_valid) starve = (starve < SL) ? starve + 1 : SL;
      if (go) last_wb = pick;
      gf = e_f; gs = e_st; gl = go && !pick; gw = go && pick;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fill_wr_valid = 1'b0; st_wr_valid = 1'b0; ld_rd_valid = 1'b0; wb_rd_valid = 1'b0;
    fill_wr_addr = '0; st_wr_addr = '0; ld_rd_addr = '0; wb_rd_addr = '0;
    fill_wr_data = '0; st_wr_data = '0; st_wr_mask = '0;
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      seed_v = 1'b1; seed_a = 8'(a); seed_d = rnd_line(); ref_mem[a] = seed_d;
    end
    @(negedge clk); seed_v = 1'b0;
    test_reset();
    test_starvation();
    test_round_robin();
    test_conflict();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
